// File: rtl/multicycle_sequencer.sv
// Control FSM for the non-pipelined core: steps FETCH/DECODE/EXECUTE/MEM/WB,
// drives the memory request handshakes and write strobes, and counts retired instructions.
module multicycle_sequencer #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_reg_write,
  input  logic             dec_reg_write_from_load,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             reg_write_en,
  output logic             wb_sel_load,
  output logic             pc_write,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_count
);

  // Handshake: imem_req/dmem_req rise on entry to FETCH/MEM and stay high until
  // the cycle the matching ack is seen; an ack outside those states has no effect.

  localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2 || XLEN < 1) begin : g_param_check
    $error("multicycle_sequencer: TIMEOUT_CYCLES must be >= 2 and XLEN >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t            cur;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_op;
  logic              mem_conflict;

  assign mem_op       = dec_mem_read ^ dec_mem_write;
  assign mem_conflict = dec_mem_read & dec_mem_write;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur           <= S_IDLE;
      wait_cnt      <= '0;
      retired_count <= '0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (run) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (imem_ack) begin
            cur      <= S_DECODE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            cur      <= S_FAULT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          cur      <= S_EXECUTE;
          wait_cnt <= '0;
        end
        S_EXECUTE: begin
          wait_cnt <= '0;
          if (mem_conflict) begin
            cur <= S_FAULT;
          end else if (mem_op) begin
            cur <= S_MEM;
          end else begin
            cur <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            cur      <= S_WB;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            cur      <= S_FAULT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          retired_count <= retired_count + CNT_W'(1);
          wait_cnt      <= '0;
          cur           <= run ? S_FETCH : S_IDLE;
        end
        S_FAULT: begin
          cur      <= S_FAULT;
          wait_cnt <= '0;
        end
        default: begin
          cur      <= S_FAULT;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign imem_req     = (cur == S_FETCH);
  assign ir_load      = (cur == S_FETCH) & imem_ack;
  assign dmem_req     = (cur == S_MEM);
  assign dmem_we      = (cur == S_MEM) & dec_mem_write;
  assign reg_write_en = (cur == S_WB) & dec_reg_write;
  assign wb_sel_load  = (cur == S_WB) & dec_reg_write_from_load;
  assign pc_write     = (cur == S_WB);
  assign halted       = (cur == S_IDLE);
  // The unused code 7 is reported as a fault as well.
  assign fault        = (cur == S_FAULT) || (cur == state_t'(3'd7));
  assign state        = cur;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: an instruction-level model turns each planned
// instruction (kind, fetch wait, mem wait) into the expected per-cycle output trace.
module tb_multicycle_sequencer;

  localparam int TO    = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run = 1'b0;
  logic             imem_req, imem_ack = 1'b0, ir_load;
  logic             dec_mem_read = 1'b0, dec_mem_write = 1'b0;
  logic             dec_reg_write = 1'b0, dec_reg_write_from_load = 1'b0;
  logic             dmem_req, dmem_we, dmem_ack = 1'b0;
  logic             reg_write_en, wb_sel_load, pc_write, halted, fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired_count;

  int               checks = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_retired = '0;

  multicycle_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .dec_reg_write_from_load(dec_reg_write_from_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_write_en(reg_write_en), .wb_sel_load(wb_sel_load), .pc_write(pc_write),
    .halted(halted), .fault(fault), .state(state), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Record layout: {state[2:0], imem_req, ir_load, dmem_req, dmem_we,
  //                 reg_write_en, wb_sel_load, pc_write, halted, fault}
  function automatic logic [11:0] rec(int s, bit ireq, bit il, bit dreq, bit dwe,
                                      bit rwe, bit wbs, bit pcw);
    logic [2:0] s3;
    s3 = 3'(s);
    return {s3, ireq, il, dreq, dwe, rwe, wbs, pcw, (s == 0), (s == 6)};
  endfunction

  function automatic logic [11:0] observed();
    return {state, imem_req, ir_load, dmem_req, dmem_we,
            reg_write_en, wb_sel_load, pc_write, halted, fault};
  endfunction

  // All tasks start and end at posedge+#1; outputs are sampled at the negedge.
  task automatic do_reset();
    rst = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_retired = '0;
  endtask

  task automatic check_idle(input string name);
    imem_ack = 1'($urandom_range(0, 1));
    dmem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if (observed() !== rec(0, 0, 0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, observed(), rec(0, 0, 0, 0, 0, 0, 0, 0));
    end
    @(posedge clk); #1;
  endtask

  task automatic check_retired(input string name);
    checks++;
    if (retired_count !== exp_retired) begin
      failures++;
      $display("FAIL %s: retired_count got %0d expected %0d", name, retired_count, exp_retired);
    end
  endtask

  // One IDLE cycle with run high; the next cycle must be FETCH.
  task automatic go_from_idle();
    run = 1'b1;
    check_idle("idle_before_start");
  endtask

  // Plays one instruction starting in its first FETCH cycle. fw/mw are the number of
  // wait cycles before the ack; a value >= TO means the ack never comes.
  task automatic run_instr(input bit ld, input bit st, input bit rw, input bit rwl,
                           input int fw, input int mw, input bit drop_run);
    logic [11:0] exp_q[$];
    logic [11:0] e;
    int          fetch_ack_idx;
    int          mem_ack_idx;
    bit          retires;
    retires = 1'b0;
    fetch_ack_idx = -1;
    mem_ack_idx = -1;
    if (fw >= TO) begin
      for (int i = 0; i < TO; i++) exp_q.push_back(rec(1, 1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 8; i++) exp_q.push_back(rec(6, 0, 0, 0, 0, 0, 0, 0));
    end else begin
      for (int i = 0; i <= fw; i++) exp_q.push_back(rec(1, 1, (i == fw), 0, 0, 0, 0, 0));
      fetch_ack_idx = fw;
      exp_q.push_back(rec(2, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(rec(3, 0, 0, 0, 0, 0, 0, 0));
      if (ld && st) begin
        for (int i = 0; i < 8; i++) exp_q.push_back(rec(6, 0, 0, 0, 0, 0, 0, 0));
      end else begin
        if (ld || st) begin
          if (mw >= TO) begin
            for (int i = 0; i < TO; i++) exp_q.push_back(rec(4, 0, 0, 1, st, 0, 0, 0));
            for (int i = 0; i < 8; i++) exp_q.push_back(rec(6, 0, 0, 0, 0, 0, 0, 0));
          end else begin
            mem_ack_idx = exp_q.size() + mw;
            for (int i = 0; i <= mw; i++) exp_q.push_back(rec(4, 0, 0, 1, st, 0, 0, 0));
          end
        end
        if (!(ld || st) || mw < TO) begin
          exp_q.push_back(rec(5, 0, 0, 0, 0, rw, rwl, 1));
          retires = 1'b1;
        end
      end
    end
    dec_mem_read = ld; dec_mem_write = st;
    dec_reg_write = rw; dec_reg_write_from_load = rwl;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      imem_ack = (e[11:9] == 3'd1) ? (i == fetch_ack_idx) : 1'($urandom_range(0, 1));
      dmem_ack = (e[11:9] == 3'd4) ? (i == mem_ack_idx) : 1'($urandom_range(0, 1));
      if (e[11:9] == 3'd6) run = 1'($urandom_range(0, 1));
      if (drop_run && e[11:9] == 3'd3) run = 1'b0;
      @(negedge clk);
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL trace cycle %0d (ld=%0d st=%0d fw=%0d mw=%0d): got %h expected %h",
                 i, ld, st, fw, mw, observed(), e);
      end
      @(posedge clk); #1;
    end
    if (retires) begin
      exp_retired = exp_retired + CNT_W'(1);
      check_retired("retired_after_wb");
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle("reset_outputs");
    check_retired("reset_retired");
    check_idle("idle_holds_without_run");
  endtask

  task automatic test_alu();
    do_reset();
    go_from_idle();
    run_instr(0, 0, 1, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load();
    run_instr(1, 0, 1, 1, 0, 2, 0);
  endtask

  task automatic test_store();
    run_instr(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int kind;
    int fw;
    int mw;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 2);
      fw = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 3);
      case (kind)
        0: run_instr(0, 0, 1'($urandom_range(0, 1)), 0, fw, mw, (n == 23));
        1: run_instr(1, 0, 1, 1, fw, mw, (n == 23));
        default: run_instr(0, 1, 0, 0, fw, mw, (n == 23));
      endcase
    end
    run = 1'b0;
    check_idle("idle_after_stream");
  endtask

  task automatic test_run_drop();
    go_from_idle();
    run_instr(0, 0, 1, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) check_idle("idle_after_run_drop");
    go_from_idle();
    run_instr(1, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    go_from_idle();
    run_instr(0, 0, 1, 0, TO, 0, 0);
    do_reset();
    check_idle("idle_after_fault_reset");
    check_retired("retired_after_fault_reset");
    go_from_idle();
    run_instr(0, 0, 1, 0, TO - 1, 0, 0);
  endtask

  task automatic test_mem_timeout();
    do_reset();
    go_from_idle();
    run_instr(1, 0, 1, 1, 0, TO, 0);
    do_reset();
    check_idle("idle_after_mem_fault_reset");
  endtask

  task automatic test_illegal();
    do_reset();
    go_from_idle();
    run_instr(1, 1, 1, 0, 0, 0, 0);
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    int steps[5] = '{1, 2, 3, 4, 4};
    do_reset();
    go_from_idle();
    dec_mem_read = 1'b1; dec_mem_write = 1'b0;
    dec_reg_write = 1'b1; dec_reg_write_from_load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_ack = (i == 0);
      dmem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== 3'(steps[i])) begin
        failures++;
        $display("FAIL mid_mem_walk cycle %0d: state got %0d expected %0d", i, state, steps[i]);
      end
      if (i == 4) begin
        rst = 1'b0;
        run = 1'b0;
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    exp_retired = '0;
    for (int i = 0; i < 3; i++) check_idle("after_mid_mem_reset");
    check_retired("retired_after_mid_mem_reset");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_run_drop();
    test_fetch_timeout();
    test_mem_timeout();
    test_illegal();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
